// File: rtl/bram_prog_loader.sv
// bram_prog_loader: streams words into instruction BRAM, reads them back and
// compares the read sum against the write sum while holding the core in reset.
module bram_prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic                  w_enb,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_enb,
  input  logic [DATA_WIDTH-1:0] r_dat,
  output logic                  busy,
  output logic                  core_hold,
  output logic                  done,
  output logic                  verify_err
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

  state_t                r_state, w_state;
  logic [CW-1:0]         r_n, w_n, r_wcnt, w_wcnt, r_rcnt, w_rcnt, r_ccnt, w_ccnt;
  logic [DATA_WIDTH-1:0] r_wsum, w_wsum, r_rsum, w_rsum, r_w_dat, w_w_dat;
  logic [ADDR_WIDTH-1:0] r_w_addr, w_w_addr, r_r_addr, w_r_addr;
  logic                  r_ovf, w_ovf, r_s_ready, w_s_ready, r_w_enb, w_w_enb;
  logic                  r_r_enb, w_r_enb, r_rd_v, w_rd_v, r_busy, w_busy;
  logic                  r_done, w_done, r_err, w_err;
  logic                  w_hs;

  assign w_hs       = s_valid & r_s_ready;
  assign s_ready    = r_s_ready;
  assign w_addr     = r_w_addr;
  assign w_dat      = r_w_dat;
  assign w_enb      = r_w_enb;
  assign r_addr     = r_r_addr;
  assign r_enb      = r_r_enb;
  assign busy       = r_busy;
  assign core_hold  = r_busy;
  assign done       = r_done;
  assign verify_err = r_err;

  always_comb begin
    w_state   = r_state;
    w_n       = r_n;
    w_wcnt    = r_wcnt;
    w_rcnt    = r_rcnt;
    w_ccnt    = r_ccnt;
    w_wsum    = r_wsum;
    w_rsum    = r_rsum;
    w_ovf     = r_ovf;
    w_s_ready = r_s_ready;
    w_w_addr  = r_w_addr;
    w_w_dat   = r_w_dat;
    w_w_enb   = 1'b0;
    w_r_addr  = r_r_addr;
    w_r_enb   = 1'b0;
    w_rd_v    = r_r_enb;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_err     = r_err;
    case (r_state)
      IDLE: if (start) begin
        w_n       = word_count;
        w_wcnt    = '0;
        w_rcnt    = '0;
        w_ccnt    = '0;
        w_wsum    = '0;
        w_rsum    = '0;
        w_err     = 1'b0;
        w_ovf     = word_count > MAXW;
        w_state   = (word_count == '0 || w_ovf) ? FINISH : LOAD;
        w_s_ready = w_state == LOAD;
        w_busy    = w_state == LOAD;
      end
      LOAD: begin
        if (w_hs) begin
          w_w_enb  = 1'b1;
          w_w_addr = r_wcnt[ADDR_WIDTH-1:0];
          w_w_dat  = s_dat;
          w_wsum   = r_wsum + s_dat;
          w_wcnt   = r_wcnt + CW'(1);
        end
        w_s_ready = w_wcnt < r_n;
        // the last write is on the port this cycle, so the first read can follow it
        if (r_w_enb && r_wcnt == r_n) begin
          w_state  = VERIFY;
          w_r_enb  = 1'b1;
          w_r_addr = '0;
          w_rcnt   = CW'(1);
        end
      end
      VERIFY: begin
        if (r_rcnt < r_n) begin
          w_r_enb  = 1'b1;
          w_r_addr = r_rcnt[ADDR_WIDTH-1:0];
          w_rcnt   = r_rcnt + CW'(1);
        end
        if (r_rd_v) begin
          w_rsum  = r_rsum + r_dat;
          w_ccnt  = r_ccnt + CW'(1);
          w_state = (r_ccnt == r_n - CW'(1)) ? FINISH : VERIFY;
        end
      end
      FINISH: begin
        w_state = IDLE;
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_err   = r_ovf | (r_rsum != r_wsum);
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_ccnt    <= '0;
      r_wsum    <= '0;
      r_rsum    <= '0;
      r_ovf     <= 1'b0;
      r_s_ready <= 1'b0;
      r_w_addr  <= '0;
      r_w_dat   <= '0;
      r_w_enb   <= 1'b0;
      r_r_addr  <= '0;
      r_r_enb   <= 1'b0;
      r_rd_v    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_n       <= w_n;
      r_wcnt    <= w_wcnt;
      r_rcnt    <= w_rcnt;
      r_ccnt    <= w_ccnt;
      r_wsum    <= w_wsum;
      r_rsum    <= w_rsum;
      r_ovf     <= w_ovf;
      r_s_ready <= w_s_ready;
      r_w_addr  <= w_w_addr;
      r_w_dat   <= w_w_dat;
      r_w_enb   <= w_w_enb;
      r_r_addr  <= w_r_addr;
      r_r_enb   <= w_r_enb;
      r_rd_v    <= w_rd_v;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end
endmodule

// File: tb/tb_bram_prog_loader.sv
// tb_bram_prog_loader: table-driven loads against a BRAM model with a write scoreboard,
// plus a hand-written asynchronous-abort sequence.
module tb_bram_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic [31:0] s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [9:0]  w_addr;
  logic [31:0] w_dat;
  logic        w_enb;
  logic [9:0]  r_addr;
  logic        r_enb;
  logic [31:0] r_dat = '0;
  logic        busy, core_hold, done, verify_err;

  bram_prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
    .r_addr(r_addr), .r_enb(r_enb), .r_dat(r_dat),
    .busy(busy), .core_hold(core_hold), .done(done), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic gap;
    int   flip;
    logic restart;
    logic exp_err;
    int   exp_lat;
  } vec_t;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          n_writes, n_reads, n_done, exp_raddr, done_cyc;
  int          flip_addr = -1;
  logic        err_at_done;
  logic [41:0] wq[$];
  logic [31:0] mem [1024];
  logic [31:0] pat [4];
  vec_t        tbl [8];

  task automatic check(input bit ok, input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return (i < 4) ? pat[i] : (32'hC0DE_0000 ^ (32'(i) * 32'h9E37_79B9));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_enb) mem[w_addr] <= w_dat;
    if (r_enb) r_dat <= mem[r_addr] ^ ((flip_addr >= 0 && int'(r_addr) == flip_addr) ? 32'd1 : 32'd0);
  end

  always @(negedge clk) begin
    logic [41:0] e;
    if (w_enb) begin
      n_writes++;
      if (wq.size() == 0) check(1'b0, "w_extra", 64'({w_addr, w_dat}), 64'(0));
      else begin
        e = wq.pop_front();
        check({w_addr, w_dat} == e, "w_addr_dat", 64'({w_addr, w_dat}), 64'(e));
      end
    end
    if (r_enb) begin
      check(int'(r_addr) == exp_raddr, "r_addr", 64'(r_addr), 64'(exp_raddr));
      n_reads++;
      exp_raddr++;
    end
    if (w_enb && r_enb) check(1'b0, "rw_overlap", 64'(1), 64'(0));
    if (done) begin
      n_done++;
      done_cyc = cyc;
      err_at_done = verify_err;
    end
  end

  task automatic clear_sb(input int flip);
    wq.delete();
    n_writes = 0;
    n_reads = 0;
    n_done = 0;
    exp_raddr = 0;
    done_cyc = -1;
    flip_addr = flip;
  endtask

  task automatic run(input vec_t v);
    int idx = 0;
    int c0;
    int exp_w = (v.n > 0 && v.n <= 1024) ? v.n : 0;
    int budget = ((v.n > 64) ? 64 : 4 * v.n) + 40;
    clear_sb(v.flip);
    @(negedge clk); #1;
    c0 = cyc;
    word_count = 11'(v.n);
    for (int t = 0; t < budget; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
      end
      if (done_cyc >= 0) break;
      start = (t == 0) || (v.restart && t == 3);
      if (v.restart && t == 3) word_count = 11'd5;
      if (t == 1) check(verify_err == 1'b0, "err_clr_on_start", 64'(verify_err), 64'(0));
      if (t == 2) check(busy == 1'b1 && core_hold == 1'b1, "busy_hold", 64'({busy, core_hold}), 64'(3));
      s_valid = (idx < v.n) && (!v.gap || t % 2 == 0);
      s_dat = word(idx);
      if (s_valid && s_ready) begin
        wq.push_back({10'(idx), word(idx)});
        idx++;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    check(done_cyc >= 0, "done_seen", 64'(done_cyc), 64'(1));
    if (v.exp_lat >= 0) check(done_cyc - c0 == v.exp_lat, "done_lat", 64'(done_cyc - c0), 64'(v.exp_lat));
    check(err_at_done == v.exp_err, "verify_err", 64'(err_at_done), 64'(v.exp_err));
    check(n_writes == exp_w, "n_writes", 64'(n_writes), 64'(exp_w));
    check(n_reads == exp_w, "n_reads", 64'(n_reads), 64'(exp_w));
    check(wq.size() == 0, "wq_empty", 64'(wq.size()), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    check(n_done == 1, "n_done", 64'(n_done), 64'(1));
    check(verify_err == v.exp_err, "err_sticky", 64'(verify_err), 64'(v.exp_err));
    check(busy == 1'b0 && core_hold == 1'b0, "idle_busy", 64'({busy, core_hold}), 64'(0));
  endtask

  initial begin
    int idx;
    pat[0] = 32'h0000_0033;
    pat[1] = 32'h0020_81B3;
    pat[2] = 32'h4011_0133;
    pat[3] = 32'h0000_0013;
    tbl[0] = '{4,    1'b0, -1, 1'b0, 1'b0, 12};
    tbl[1] = '{4,    1'b1, -1, 1'b0, 1'b0, -1};
    tbl[2] = '{4,    1'b0,  2, 1'b0, 1'b1, 12};
    tbl[3] = '{0,    1'b0, -1, 1'b0, 1'b0,  2};
    tbl[4] = '{1025, 1'b0, -1, 1'b0, 1'b1,  2};
    tbl[5] = '{8,    1'b0, -1, 1'b1, 1'b0, 20};
    tbl[6] = '{1,    1'b0, -1, 1'b0, 1'b0,  6};
    tbl[7] = '{3,    1'b1, -1, 1'b0, 1'b0, -1};
    clear_sb(-1);
    repeat (3) @(negedge clk);
    #1;
    check({s_ready, w_addr, w_dat, w_enb, r_addr, r_enb, busy, core_hold, done, verify_err} == '0,
          "reset_outs", 64'({s_ready, w_enb, r_enb, busy, core_hold, done, verify_err}), 64'(0));
    rst = 1'b1;
    for (int i = 0; i < 8; i++) run(tbl[i]);

    clear_sb(-1);
    idx = 0;
    @(negedge clk); #1;
    word_count = 11'd8;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
      end
      if (n_writes >= 3) break;
      start = (t == 0);
      s_valid = idx < 8;
      s_dat = word(idx);
      if (s_valid && s_ready) begin
        wq.push_back({10'(idx), word(idx)});
        idx++;
      end
    end
    start = 1'b0;
    check(n_writes == 3, "abort_wr3", 64'(n_writes), 64'(3));
    rst = 1'b0;
    #1;
    check({s_ready, w_addr, w_dat, w_enb, r_addr, r_enb, busy, core_hold, done, verify_err} == '0,
          "abort_outs", 64'({s_ready, w_enb, r_enb, busy, core_hold, done, verify_err}), 64'(0));
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    check(n_done == 0, "abort_no_done", 64'(n_done), 64'(0));
    #1;
    rst = 1'b1;
    run('{2, 1'b0, -1, 1'b0, 1'b0, 8});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
